ped_crossing_ctrl: RTL and testbench
====================================

Name: ped_crossing_ctrl

Overview:
- Pedestrian-signal controller that sits directly downstream of the vehicle traffic-light FSM.
- Inputs: the car lamp outputs (red/yellow/green) and a raw pedestrian push-button.
- Outputs: WALK / DONT_WALK lamps and a "request pending" lamp.
- WALK is granted only inside a red-only car phase, and only after a latched request.
- Any loss of red-only, or an illegal lamp combination, forces DONT_WALK at once.

Parameters:
- WALK_TIME, 4: cycles of steady WALK (>=1).
- BLINK_TIME, 4: cycles of blinking WALK after the steady phase (>=1).
- BLINK_HALF, 1: cycles per blink half-period (>=1). WALK is on in the first half.
- CNT_W, 8: width of the phase and blink counters. Must hold max(WALK_TIME, BLINK_TIME).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- i_red  in  1  car red lamp (from the traffic FSM).
- i_yellow  in  1  car yellow lamp.
- i_green  in  1  car green lamp.
- i_btn  in  1  raw pedestrian button, asynchronous, active-high.
- o_walk  out  1  WALK lamp, registered.
- o_dont_walk  out  1  DONT_WALK lamp, registered.
- o_wait  out  1  request-pending lamp, registered.
- o_abort  out  1  one-cycle pulse when a WALK/BLINK phase is cut short.
- o_fault  out  1  sticky error flag. Cleared only by rst.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State = DONT_WALK.
  - o_walk=0, o_dont_walk=1, o_wait=0, o_abort=0, o_fault=0.
  - Synchronizer flops, req, red_ok_d and all counters are cleared.
  - Reset mid-WALK/BLINK takes effect at the same edge.
- Button path:
  - 2-flop synchronizer, then rising-edge detect (btn_rise).
  - req sets on btn_rise, so o_wait is high 3 edges after i_btn rises.
  - A held button produces one request only.
  - btn_rise during WALK or BLINK is ignored (not latched).
- red_ok = i_red & ~i_yellow & ~i_green.
  - red_ok_d is its 1-cycle registered copy.
  - red_start = red_ok & ~red_ok_d.
- Illegal lamp combination: i_green together with (i_red or i_yellow).
  - o_fault <= 1 (sticky).
  - State is forced to DONT_WALK and held there while o_fault=1.
  - req is cleared.
  - An illegal combination occurring in WALK/BLINK also pulses o_abort.
- States (outputs are a registered decode of the next state, so there is 1 cycle of latency from the deciding edge):
  - DONT_WALK: o_dont_walk=1, o_walk=0.
    - If red_start & (req | btn_rise) & ~o_fault: go to WALK, load cnt=WALK_TIME, clear req.
    - A request that arrives after red_start waits for the next red phase.
  - WALK: o_walk=1, o_dont_walk=0. cnt decrements each cycle.
    - At cnt==1: go to BLINK, load cnt=BLINK_TIME, clear the blink counter.
  - BLINK: o_dont_walk=0.
    - o_walk is 1 for BLINK_HALF cycles, then 0 for BLINK_HALF cycles, repeating. The pattern restarts at BLINK entry.
    - At cnt==1: go to DONT_WALK.
- Abort: red_ok==0 while in WALK or BLINK.
  - Next state is DONT_WALK.
  - o_abort is high for exactly 1 cycle, coincident with o_dont_walk rising.
  - req stays cleared.
- Lamp invariant: o_walk & o_dont_walk is never 1. o_dont_walk=0 only in WALK/BLINK.
- Simultaneous events:
  - rst has priority over everything.
  - Fault has priority over abort and over start.
  - btn_rise in the same cycle as red_start counts as a request, and the request is consumed immediately.

Test Plan:
- Reset: rst=1 for 2 clk with random inputs -> o_dont_walk=1, o_walk=0, o_wait=0, o_fault=0, o_abort=0.
- Normal grant:
  - Stimulus: pulse i_btn during green; o_wait rises 3 edges later; then drive red-only for 20 cycles.
  - Response with defaults: o_wait drops and o_walk=1 one cycle after red_start.
  - o_walk holds for 4 cycles, then toggles 1,0,1,0 over 4 cycles.
  - o_dont_walk=1 afterwards. Check o_walk & o_dont_walk==0 every cycle.
- No request: a red-only phase with no button press -> o_walk stays 0 for the whole phase.
- Late request: press i_btn 3 cycles after red_start -> no WALK in that phase; WALK occurs at the next red_start.
- Abort: during WALK cycle 2, raise i_yellow -> next cycle o_dont_walk=1, o_walk=0, one-cycle o_abort=1, o_fault stays 0.
- Fault: drive i_green=1 & i_red=1 for 1 cycle during WALK -> o_fault=1 (sticky), o_abort pulses, DONT_WALK held.
  - A later request plus red_start gives no WALK until rst.

Source files
------------

// File: rtl/ped_crossing_ctrl.sv
// ----------------------------------------------------------------------------
// ped_crossing_ctrl
//
// Pedestrian-signal controller placed downstream of the vehicle traffic-light
// FSM. A pedestrian request (from a raw push-button) is latched and WALK is
// granted only at the start of a red-only car phase. Any loss of red-only
// during WALK/BLINK, or an illegal car lamp combination, drops straight back
// to DONT_WALK.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous, active-high reset
//   i_red        car red lamp
//   i_yellow     car yellow lamp
//   i_green      car green lamp
//   i_btn        raw pedestrian button (asynchronous, active-high)
//   o_walk       WALK lamp (registered)
//   o_dont_walk  DONT_WALK lamp (registered)
//   o_wait       request-pending lamp (registered)
//   o_abort      one-cycle pulse when WALK/BLINK is cut short
//   o_fault      sticky illegal-lamp flag, cleared only by rst
//
// State table
//   state         | meaning
//   --------------+----------------------------------------------------------
//   ST_DONT_WALK  | pedestrians held; waiting for red_start with a request
//   ST_WALK       | steady WALK, r_cnt counts down WALK_TIME cycles
//   ST_BLINK      | blinking WALK, r_cnt counts down BLINK_TIME cycles
// ----------------------------------------------------------------------------
module ped_crossing_ctrl #(
    parameter int WALK_TIME  = 4,
    parameter int BLINK_TIME = 4,
    parameter int BLINK_HALF = 1,
    parameter int CNT_W      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_red,
    input  logic i_yellow,
    input  logic i_green,
    input  logic i_btn,
    output logic o_walk,
    output logic o_dont_walk,
    output logic o_wait,
    output logic o_abort,
    output logic o_fault
);

    typedef enum logic [1:0] {
        ST_DONT_WALK = 2'd0,
        ST_WALK      = 2'd1,
        ST_BLINK     = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LP_WALK_LOAD  = CNT_W'(WALK_TIME);
    localparam logic [CNT_W-1:0] LP_BLINK_LOAD = CNT_W'(BLINK_TIME);
    localparam logic [CNT_W-1:0] LP_HALF_LOAD  = CNT_W'(BLINK_HALF);
    localparam logic [CNT_W-1:0] LP_ONE        = CNT_W'(1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_blink_cnt;
    logic               r_blink_on;
    logic               r_btn_s1;
    logic               r_btn_s2;
    logic               r_btn_d;
    logic               r_req;
    logic               r_red_ok_d;

    logic               w_red_ok;
    logic               w_red_start;
    logic               w_btn_rise;
    logic               w_illegal;
    logic               w_in_walk;

    assign w_red_ok    = i_red & ~i_yellow & ~i_green;
    assign w_red_start = w_red_ok & ~r_red_ok_d;
    assign w_btn_rise  = r_btn_s2 & ~r_btn_d;
    assign w_illegal   = i_green & (i_red | i_yellow);
    assign w_in_walk   = (r_state == ST_WALK) || (r_state == ST_BLINK);

    // The request register drives the pending lamp directly.
    assign o_wait = r_req;

    // Lamp outputs are written alongside the state so they always reflect
    // the state being entered at this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_DONT_WALK;
            r_cnt       <= '0;
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b0;
            r_btn_s1    <= 1'b0;
            r_btn_s2    <= 1'b0;
            r_btn_d     <= 1'b0;
            r_req       <= 1'b0;
            r_red_ok_d  <= 1'b0;
            o_walk      <= 1'b0;
            o_dont_walk <= 1'b1;
            o_abort     <= 1'b0;
            o_fault     <= 1'b0;
        end else begin
            r_btn_s1   <= i_btn;
            r_btn_s2   <= r_btn_s1;
            r_btn_d    <= r_btn_s2;
            r_red_ok_d <= w_red_ok;
            o_abort    <= 1'b0;

            if (w_illegal) begin
                // Fault outranks both abort and start.
                o_fault     <= 1'b1;
                r_req       <= 1'b0;
                r_state     <= ST_DONT_WALK;
                o_walk      <= 1'b0;
                o_dont_walk <= 1'b1;
                if (w_in_walk) begin
                    o_abort <= 1'b1;
                end
            end else begin
                case (r_state)
                    ST_DONT_WALK: begin
                        o_walk      <= 1'b0;
                        o_dont_walk <= 1'b1;
                        // A button edge coinciding with red_start is consumed
                        // immediately instead of being latched.
                        if (w_red_start && (r_req || w_btn_rise) && !o_fault) begin
                            r_state     <= ST_WALK;
                            r_cnt       <= LP_WALK_LOAD;
                            r_req       <= 1'b0;
                            o_walk      <= 1'b1;
                            o_dont_walk <= 1'b0;
                        end else if (w_btn_rise) begin
                            r_req <= 1'b1;
                        end
                    end

                    ST_WALK: begin
                        if (!w_red_ok) begin
                            r_state     <= ST_DONT_WALK;
                            o_walk      <= 1'b0;
                            o_dont_walk <= 1'b1;
                            o_abort     <= 1'b1;
                        end else if (r_cnt == LP_ONE) begin
                            r_state     <= ST_BLINK;
                            r_cnt       <= LP_BLINK_LOAD;
                            r_blink_cnt <= LP_HALF_LOAD;
                            r_blink_on  <= 1'b1;
                            o_walk      <= 1'b1;
                            o_dont_walk <= 1'b0;
                        end else begin
                            r_cnt       <= r_cnt - LP_ONE;
                            o_walk      <= 1'b1;
                            o_dont_walk <= 1'b0;
                        end
                    end

                    ST_BLINK: begin
                        if (!w_red_ok) begin
                            r_state     <= ST_DONT_WALK;
                            o_walk      <= 1'b0;
                            o_dont_walk <= 1'b1;
                            o_abort     <= 1'b1;
                        end else if (r_cnt == LP_ONE) begin
                            r_state     <= ST_DONT_WALK;
                            o_walk      <= 1'b0;
                            o_dont_walk <= 1'b1;
                        end else begin
                            r_cnt       <= r_cnt - LP_ONE;
                            o_dont_walk <= 1'b0;
                            // Half-period down-counter; flip the lamp phase on
                            // terminal count.
                            if (r_blink_cnt == LP_ONE) begin
                                r_blink_cnt <= LP_HALF_LOAD;
                                r_blink_on  <= ~r_blink_on;
                                o_walk      <= ~r_blink_on;
                            end else begin
                                r_blink_cnt <= r_blink_cnt - LP_ONE;
                                o_walk      <= r_blink_on;
                            end
                        end
                    end

                    default: begin
                        r_state     <= ST_DONT_WALK;
                        o_walk      <= 1'b0;
                        o_dont_walk <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ped_crossing_ctrl
//
// Directed testbench for ped_crossing_ctrl with default parameters. Inputs are
// driven 1 time unit after the rising edge; outputs are checked at the same
// point, i.e. they show the result of the edge just taken.
// ----------------------------------------------------------------------------
module tb_ped_crossing_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_red = 1'b0;
    logic i_yellow = 1'b0;
    logic i_green = 1'b1;
    logic i_btn = 1'b0;
    logic o_walk;
    logic o_dont_walk;
    logic o_wait;
    logic o_abort;
    logic o_fault;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ped_crossing_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .i_red       (i_red),
        .i_yellow    (i_yellow),
        .i_green     (i_green),
        .i_btn       (i_btn),
        .o_walk      (o_walk),
        .o_dont_walk (o_dont_walk),
        .o_wait      (o_wait),
        .o_abort     (o_abort),
        .o_fault     (o_fault)
    );

    // Both lamps lit together is never allowed.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            checks++;
            if ((o_walk & o_dont_walk) !== 1'b0) begin
                errors++;
                $display("FAIL lamp_invariant: walk=%b dont_walk=%b at %0t", o_walk, o_dont_walk, $time);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lamps(input logic r, input logic y, input logic g);
        i_red    = r;
        i_yellow = y;
        i_green  = g;
    endtask

    // Press during green, let the request latch, then switch to red-only.
    // Returns just after the red_start edge.
    task automatic start_walk();
        set_lamps(1'b0, 1'b0, 1'b1);
        tick();
        i_btn = 1'b1;
        tick();
        i_btn = 1'b0;
        tick();
        tick();
        set_lamps(1'b1, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            {i_red, i_yellow, i_green, i_btn} = 4'($urandom_range(0, 15));
            tick();
        end
        checks++; if (o_dont_walk !== 1'b1) begin errors++; $display("FAIL reset_dont_walk: got %b want 1", o_dont_walk); end
        checks++; if (o_walk !== 1'b0) begin errors++; $display("FAIL reset_walk: got %b want 0", o_walk); end
        checks++; if (o_wait !== 1'b0) begin errors++; $display("FAIL reset_wait: got %b want 0", o_wait); end
        checks++; if (o_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", o_fault); end
        checks++; if (o_abort !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b want 0", o_abort); end
        set_lamps(1'b0, 1'b0, 1'b1);
        i_btn = 1'b0;
        rst   = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_normal_grant();
        logic [8:0] exp_walk;
        logic [8:0] exp_dw;
        // Index 0 is the red_start edge: 4 steady, 1,0,1,0 blink, then DONT_WALK.
        exp_walk = 9'b0_0101_1111;
        exp_dw   = 9'b1_0000_0000;
        set_lamps(1'b0, 1'b0, 1'b1);
        i_btn = 1'b1;
        tick();
        checks++; if (o_wait !== 1'b0) begin errors++; $display("FAIL grant_wait_edge1: got %b want 0", o_wait); end
        i_btn = 1'b0;
        tick();
        checks++; if (o_wait !== 1'b0) begin errors++; $display("FAIL grant_wait_edge2: got %b want 0", o_wait); end
        tick();
        checks++; if (o_wait !== 1'b1) begin errors++; $display("FAIL grant_wait_edge3: got %b want 1", o_wait); end
        set_lamps(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i < 9) begin
                checks++; if (o_walk !== exp_walk[i]) begin errors++; $display("FAIL grant_walk[%0d]: got %b want %b", i, o_walk, exp_walk[i]); end
                checks++; if (o_dont_walk !== exp_dw[i]) begin errors++; $display("FAIL grant_dont_walk[%0d]: got %b want %b", i, o_dont_walk, exp_dw[i]); end
            end else begin
                checks++; if (o_walk !== 1'b0 || o_dont_walk !== 1'b1) begin errors++; $display("FAIL grant_after[%0d]: walk=%b dont_walk=%b want 0/1", i, o_walk, o_dont_walk); end
            end
            checks++; if (o_wait !== 1'b0) begin errors++; $display("FAIL grant_wait_cleared[%0d]: got %b want 0", i, o_wait); end
        end
        set_lamps(1'b0, 1'b0, 1'b1);
        tick();
        tick();
    endtask

    task automatic test_no_request();
        set_lamps(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (o_walk !== 1'b0 || o_dont_walk !== 1'b1) begin errors++; $display("FAIL noreq[%0d]: walk=%b dont_walk=%b want 0/1", i, o_walk, o_dont_walk); end
        end
        set_lamps(1'b0, 1'b0, 1'b1);
        tick();
        tick();
    endtask

    task automatic test_late_request();
        set_lamps(1'b1, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        tick();
        i_btn = 1'b1;
        tick();
        tick();
        i_btn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (o_walk !== 1'b0) begin errors++; $display("FAIL late_no_walk[%0d]: got %b want 0", i, o_walk); end
        end
        checks++; if (o_wait !== 1'b1) begin errors++; $display("FAIL late_wait_pending: got %b want 1", o_wait); end
        set_lamps(1'b0, 1'b0, 1'b1);
        tick();
        tick();
        checks++; if (o_walk !== 1'b0) begin errors++; $display("FAIL late_green_walk: got %b want 0", o_walk); end
        set_lamps(1'b1, 1'b0, 1'b0);
        tick();
        checks++; if (o_walk !== 1'b1) begin errors++; $display("FAIL late_next_red_walk: got %b want 1", o_walk); end
        checks++; if (o_wait !== 1'b0) begin errors++; $display("FAIL late_next_red_wait: got %b want 0", o_wait); end
        for (int i = 0; i < 8; i++) tick();
        checks++; if (o_dont_walk !== 1'b1) begin errors++; $display("FAIL late_done_dont_walk: got %b want 1", o_dont_walk); end
        set_lamps(1'b0, 1'b0, 1'b1);
        tick();
        tick();
    endtask

    task automatic test_btn_at_red_start();
        set_lamps(1'b0, 1'b0, 1'b1);
        tick();
        i_btn = 1'b1;
        tick();
        tick();
        set_lamps(1'b1, 1'b0, 1'b0);
        tick();
        checks++; if (o_walk !== 1'b1) begin errors++; $display("FAIL coincident_walk: got %b want 1", o_walk); end
        checks++; if (o_wait !== 1'b0) begin errors++; $display("FAIL coincident_wait: got %b want 0", o_wait); end
        for (int i = 0; i < 8; i++) tick();
        checks++; if (o_dont_walk !== 1'b1 || o_wait !== 1'b0) begin errors++; $display("FAIL held_btn_after: dont_walk=%b wait=%b want 1/0", o_dont_walk, o_wait); end
        set_lamps(1'b0, 1'b0, 1'b1);
        tick();
        tick();
        set_lamps(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (o_walk !== 1'b0) begin errors++; $display("FAIL held_btn_no_rewalk[%0d]: got %b want 0", i, o_walk); end
        end
        i_btn = 1'b0;
        set_lamps(1'b0, 1'b0, 1'b1);
        tick();
        tick();
    endtask

    task automatic test_abort();
        start_walk();
        checks++; if (o_walk !== 1'b1) begin errors++; $display("FAIL abort_walk1: got %b want 1", o_walk); end
        tick();
        i_yellow = 1'b1;
        tick();
        checks++; if (o_dont_walk !== 1'b1 || o_walk !== 1'b0) begin errors++; $display("FAIL abort_lamps: walk=%b dont_walk=%b want 0/1", o_walk, o_dont_walk); end
        checks++; if (o_abort !== 1'b1) begin errors++; $display("FAIL abort_pulse: got %b want 1", o_abort); end
        checks++; if (o_fault !== 1'b0) begin errors++; $display("FAIL abort_no_fault: got %b want 0", o_fault); end
        checks++; if (o_wait !== 1'b0) begin errors++; $display("FAIL abort_wait: got %b want 0", o_wait); end
        tick();
        checks++; if (o_abort !== 1'b0) begin errors++; $display("FAIL abort_one_cycle: got %b want 0", o_abort); end
        set_lamps(1'b0, 1'b0, 1'b1);
        tick();
        tick();
    endtask

    task automatic test_fault();
        start_walk();
        tick();
        set_lamps(1'b1, 1'b0, 1'b1);
        tick();
        checks++; if (o_fault !== 1'b1) begin errors++; $display("FAIL fault_set: got %b want 1", o_fault); end
        checks++; if (o_abort !== 1'b1) begin errors++; $display("FAIL fault_abort: got %b want 1", o_abort); end
        checks++; if (o_dont_walk !== 1'b1 || o_walk !== 1'b0) begin errors++; $display("FAIL fault_lamps: walk=%b dont_walk=%b want 0/1", o_walk, o_dont_walk); end
        set_lamps(1'b1, 1'b0, 1'b0);
        tick();
        checks++; if (o_abort !== 1'b0 || o_fault !== 1'b1) begin errors++; $display("FAIL fault_sticky: abort=%b fault=%b want 0/1", o_abort, o_fault); end
        start_walk();
        for (int i = 0; i < 6; i++) begin
            checks++; if (o_walk !== 1'b0 || o_dont_walk !== 1'b1 || o_fault !== 1'b1) begin errors++; $display("FAIL fault_hold[%0d]: walk=%b dont_walk=%b fault=%b want 0/1/1", i, o_walk, o_dont_walk, o_fault); end
            tick();
        end
        set_lamps(1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (o_fault !== 1'b0) begin errors++; $display("FAIL fault_cleared_by_rst: got %b want 0", o_fault); end
        tick();
    endtask

    task automatic test_reset_mid_walk();
        start_walk();
        tick();
        checks++; if (o_walk !== 1'b1) begin errors++; $display("FAIL midrst_walk_before: got %b want 1", o_walk); end
        rst = 1'b1;
        tick();
        checks++; if (o_walk !== 1'b0 || o_dont_walk !== 1'b1 || o_wait !== 1'b0) begin errors++; $display("FAIL midrst_lamps: walk=%b dont_walk=%b wait=%b want 0/1/0", o_walk, o_dont_walk, o_wait); end
        set_lamps(1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_normal_grant();
        test_no_request();
        test_late_request();
        test_btn_at_red_start();
        test_abort();
        test_fault();
        test_reset_mid_walk();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
